// File: rtl/mms_seq_ctrl.sv
// mms_seq_ctrl: sequencing controller for a serial max/min selector.
// A frame of N unsigned operands arrives one per accepted beat. A single
// compare stage folds each operand into a running best value. The frame
// max (select=1) or min (select=0) is then offered on an output handshake.
// Optional feature: define MMS_SEQ_INDEX_EN to add result_idx, the
// zero-based beat index of the winning operand.
module mms_seq_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              select,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy
`ifdef MMS_SEQ_INDEX_EN
  ,
  output logic [7:0]        result_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Beat counter value at which the accepted beat is the last of the frame.
  localparam logic [7:0] LAST = 8'(N - 1);

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] acc;
  logic [7:0]        cnt;
  logic              sel_q;
  logic              beat;
  logic              beat_last;
  logic              better;

`ifdef MMS_SEQ_INDEX_EN
  logic [7:0]        idx_q;
`endif

  // Outputs are pure decodes of registered state, so there is no input-to-output path.
  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    result    = acc;
  end

`ifdef MMS_SEQ_INDEX_EN
  assign result_idx = idx_q;
`endif

  // Beat qualification and the shared compare stage. Strict compare keeps ties on the earlier beat.
  always_comb begin
    beat      = in_valid && (state == ACC);
    beat_last = beat && (cnt == LAST);
    better    = sel_q ? (in_data > acc) : (in_data < acc);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. abort outranks beat acceptance and the output handshake.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = ACC;
        end
      end
      ACC: begin
        if (abort) begin
          state_next = IDLE;
        end else if (beat_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: mode capture at start, accumulate on accepted beats, clear count on abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      cnt   <= '0;
      sel_q <= 1'b0;
`ifdef MMS_SEQ_INDEX_EN
      idx_q <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sel_q <= select;
            cnt   <= '0;
          end
        end
        ACC: begin
          if (abort) begin
            cnt <= '0;
          end else if (beat) begin
            if ((cnt == 8'd0) || better) begin
              acc <= in_data;
`ifdef MMS_SEQ_INDEX_EN
              idx_q <= cnt;
`endif
            end
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          if (abort) begin
            cnt <= '0;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mms_seq_ctrl.sv
// Testbench for mms_seq_ctrl (N=4, DATA_W=8). A frame-level reference model
// records accepted operands and recomputes the best-so-far value and its
// index. A negedge compare process checks every output against the model on
// each cycle. Directed literal checks pin the model at key points.
module tb_mms_seq_ctrl;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       select;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       busy;
`ifdef MMS_SEQ_INDEX_EN
  logic [7:0] result_idx;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  mms_seq_ctrl #(.DATA_W(8), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .select    (select),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef MMS_SEQ_INDEX_EN
    ,
    .result_idx(result_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit         m_init = 0;
  bit         m_acc  = 0;
  bit         m_done = 0;
  bit         m_sel  = 0;
  logic [7:0] q[$];
  logic [7:0] m_result = '0;
  logic [7:0] m_idx = '0;

  task automatic recompute_best();
    logic [7:0] bv;
    int         bi;
    bv = q[0];
    bi = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (m_sel ? (q[i] > bv) : (q[i] < bv)) begin
        bv = q[i];
        bi = i;
      end
    end
    m_result = bv;
    m_idx    = 8'(bi);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_init = 1;
        m_acc = 0;
        m_done = 0;
        q.delete();
        m_result = '0;
        m_idx = '0;
      end else if (m_init) begin
        if (m_done) begin
          if (abort || out_ready) m_done = 0;
        end else if (m_acc) begin
          if (abort) begin
            m_acc = 0;
          end else if (in_valid) begin
            q.push_back(in_data);
            recompute_best();
            if (q.size() == N) begin
              m_acc = 0;
              m_done = 1;
            end
          end
        end else if (start) begin
          m_acc = 1;
          m_sel = select;
          q.delete();
        end
      end
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready",  32'(in_ready),  32'(m_acc));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      chk("busy",      32'(busy),      32'(m_acc | m_done));
      chk("result",    32'(result),    32'(m_result));
`ifdef MMS_SEQ_INDEX_EN
      chk("result_idx", 32'(result_idx), 32'(m_idx));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic sel);
    start = 1'b1;
    select = sel;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
    in_data = 8'hxx;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    select = 1'b1;
    abort = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // Reset state, with start held high during reset.
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  0);
    chk("rst_busy",      32'(busy),      0);
    chk("rst_result",    32'(result),    0);
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start_ignored_busy", 32'(busy), 0);

    // Max frame, back-to-back beats, stalled consumer.
    do_start(1'b1);
    chk("acc_in_ready", 32'(in_ready), 1);
    beat(8'h12);
    beat(8'hF0);
    beat(8'h05);
    beat(8'h80);
    chk("max_latency_valid", 32'(out_valid), 1);
    chk("max_result", 32'(result), 32'h0F0);
`ifdef MMS_SEQ_INDEX_EN
    chk("max_idx", 32'(result_idx), 1);
`endif
    gap(3);
    chk("max_stall_valid", 32'(out_valid), 1);
    chk("max_stall_result", 32'(result), 32'h0F0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("max_handshake_valid", 32'(out_valid), 0);
    chk("max_handshake_busy", 32'(busy), 0);

    // Min frame with gaps, select toggled mid-frame, tie on 0x07.
    do_start(1'b0);
    beat(8'h40);
    gap(2);
    select = 1'b1;
    beat(8'h07);
    gap(2);
    beat(8'h07);
    gap(2);
    beat(8'hFF);
    chk("min_valid", 32'(out_valid), 1);
    chk("min_result", 32'(result), 32'h07);
`ifdef MMS_SEQ_INDEX_EN
    chk("min_tie_idx", 32'(result_idx), 1);
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // All-zero frame; start coinciding with out_ready is ignored.
    do_start(1'b1);
    repeat (4) beat(8'h00);
    chk("zero_result", 32'(result), 0);
`ifdef MMS_SEQ_INDEX_EN
    chk("zero_idx", 32'(result_idx), 0);
`endif
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("start_during_handshake_busy", 32'(busy), 0);
    tick();
    start = 1'b0;
    chk("start_next_cycle_busy", 32'(busy), 1);

    // Abort after two beats, then a fresh frame must ignore the stale acc.
    beat(8'h55);
    beat(8'h66);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    gap(1);
    chk("abort_no_valid_later", 32'(out_valid), 0);
    do_start(1'b1);
    beat(8'h01);
    beat(8'h02);
    beat(8'h03);
    beat(8'h04);
    chk("post_abort_result", 32'(result), 32'h04);
`ifdef MMS_SEQ_INDEX_EN
    chk("post_abort_idx", 32'(result_idx), 3);
`endif
    // abort outranks out_ready in DONE.
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_done_valid", 32'(out_valid), 0);

    // abort in IDLE alone does nothing; start with abort in IDLE starts.
    abort = 1'b1;
    tick();
    chk("abort_idle_busy", 32'(busy), 0);
    start = 1'b1;
    select = 1'b0;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort_busy", 32'(busy), 1);
    beat(8'h90);
    beat(8'h30);
    beat(8'hA0);
    beat(8'h30);
    chk("min2_result", 32'(result), 32'h30);

    // Reset while out_valid is high.
    chk("pre_reset_valid", 32'(out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_done_valid", 32'(out_valid), 0);
    chk("reset_done_result", 32'(result), 0);
    chk("reset_done_busy", 32'(busy), 0);
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
